// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: NOP word, redirect target
// encodings and the nominal (W=16) layout of one prefetch queue entry.
package fetch_pkg;

    localparam int NOP = 0;

    typedef enum logic [1:0] {
        SEL_RDST_D = 2'b00,
        SEL_RDST_E = 2'b01,
        SEL_RET    = 2'b10,
        SEL_ISR    = 2'b11
    } redirect_sel_e;

    typedef struct packed {
        logic [15:0] word;
        logic [31:0] pc;
    } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of DEPTH entries (power of two). clear empties the
// queue and overrides push and pop in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int EW = 48,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] push_data,
    output logic [EW-1:0] head,
    output logic [CW-1:0] count
);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with a DEPTH-entry prefetch queue, redirect target mux and
// return-address assembly. Define FETCH_BYPASS_EN to forward the fetch word when the queue is empty.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int W = 16,
    parameter int SIZE = 20,
    parameter int DEPTH = 4,
    parameter logic [2*W-1:0] RESET_PC = '0,
    parameter logic [2*W-1:0] ISR_ADDR = '0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [1:0]      redirect_sel,
    input  logic [W-1:0]    Rdst_D,
    input  logic [W-1:0]    Rdst_E,
    input  logic [W-1:0]    WD,
    input  logic            pop_en,
    input  logic            pop_hi,
    input  logic            flush,
    input  logic            deq_ready,
    output logic [W-1:0]    instr,
    output logic [W-1:0]    imm,
    output logic            instr_valid,
    output logic [2*W-1:0]  pc,
    output logic [2*W-1:0]  pc_1,
    output logic [CW-1:0]   count
);

    localparam int PW = 2 * W;
    localparam int EW = W + PW;

    logic [W-1:0]  imem [2**SIZE];
    logic [PW-1:0] fetch_pc;
    logic [PW-1:0] ret_address;
    logic [PW-1:0] target;
    logic [W-1:0]  fetch_word;
    logic [W-1:0]  head_word;
    logic [PW-1:0] head_pc;
    logic [EW-1:0] q_head;
    logic          empty;
    logic          bypass;
    logic          deq;
    logic          enq;
    logic          push;
    logic          pop;

    assign fetch_word = imem[fetch_pc[SIZE-1:0]];
    assign empty      = (count == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = empty && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = (!empty || bypass) && !redirect && !flush;
    assign deq         = instr_valid && deq_ready;
    assign enq         = !redirect && ((count < CW'(DEPTH)) || deq);
    // A bypassed word consumed this cycle never enters the queue.
    assign push        = enq && !(bypass && deq);
    assign pop         = deq && !empty;

    fetch_queue #(
        .DEPTH(DEPTH),
        .EW   (EW)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect),
        .push     (push),
        .pop      (pop),
        .push_data({fetch_word, fetch_pc}),
        .head     (q_head),
        .count    (count)
    );

    always_comb begin
        head_word = q_head[EW-1:PW];
        head_pc   = q_head[PW-1:0];
        if (empty) begin
            head_pc   = fetch_pc;
            head_word = bypass ? fetch_word : W'(NOP);
        end
    end

    assign imm   = head_word;
    assign instr = instr_valid ? head_word : W'(NOP);
    assign pc    = head_pc;
    assign pc_1  = head_pc + 1'b1;

    always_comb begin
        case (redirect_sel)
            SEL_RDST_D: target = {{W{1'b0}}, Rdst_D};
            SEL_RDST_E: target = {{W{1'b0}}, Rdst_E};
            SEL_RET:    target = ret_address;
            default:    target = ISR_ADDR;
        endcase
    end

    // Return address pops are independent of redirect; SEL_RET sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            ret_address <= '0;
        end else begin
            if (redirect)
                fetch_pc <= target;
            else if (enq)
                fetch_pc <= fetch_pc + 1'b1;
            if (pop_en)
                ret_address <= pop_hi ? {WD, {W{1'b0}}} : {ret_address[PW-1:W], WD};
        end
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode. It fetches one W-bit word per cycle into a circular queue, so decode stalls no longer freeze the PC. It redirects the fetch PC on branch, jump, return or interrupt, and assembles a 2W-bit return address from W-bit popped words. It sits between the PC/instruction memory and the IF/ID pipeline register.

## Interface
- W, 16, datapath word width; PC width is 2*W
- SIZE, 20, instruction memory address bits (2**SIZE words, loaded from memory.txt)
- DEPTH, 4, prefetch queue entries, power of two, >= 2
- RESET_PC, 0, fetch PC after reset
- ISR_ADDR, 0, interrupt service routine address (2W bits)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect  in  1  load new fetch PC, discard queue
- redirect_sel  in  2  target: 00 {0,Rdst_D}, 01 {0,Rdst_E}, 10 ret_address, 11 ISR_ADDR
- Rdst_D, Rdst_E  in  W  jump targets from decode / execute
- WD  in  W  popped stack word
- pop_en  in  1  write return-address register this cycle
- pop_hi  in  1  1: load high half, clear low; 0: load low half, keep high
- flush  in  1  kill head instruction this cycle (no redirect)
- deq_ready  in  1  decode accepts head this cycle
- instr  out  W  head word, or NOP (0) when instr_valid=0
- imm  out  W  head word, never masked
- instr_valid  out  1  head present and not killed
- pc, pc_1  out  2W  head PC and head PC+1
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- State:
  - fetch_pc (2W), reset to RESET_PC
  - queue of {word, pc} with rd/wr pointers and count, reset empty
  - ret_address (2W), reset 0
- deq = instr_valid & deq_ready.
- enq = !redirect & (count<DEPTH | deq). On enq, push {imem[fetch_pc[SIZE-1:0]], fetch_pc}; fetch_pc <= fetch_pc+1 (wraps mod 2**(2W)).
- Redirect has priority over everything:
  - count <= 0, pointers reset, no enq, no deq
  - fetch_pc <= selected target
  - instr_valid=0 that cycle
- flush (redirect=0): instr_valid=0 and no deq. Enq proceeds only if count<DEPTH.
- instr_valid = (count!=0) & !redirect & !flush.
- Outputs when count=0: pc = fetch_pc, pc_1 = fetch_pc+1, imm = 0, instr = 0.
- Full queue with deq: simultaneous enq and deq, count unchanged.
- Return-address register:
  - pop_en & pop_hi: ret_address <= {WD, W'b0}
  - pop_en & !pop_hi: ret_address <= {ret_address[2W-1:W], WD}
  - Independent of redirect. A redirect with sel=10 uses the pre-edge (registered) ret_address.
- Reset mid-operation: on the next edge all state returns to reset values, whatever redirect, pop_en or deq are asserted.

## Timing
- Redirect asserted in cycle t: target word enqueued at t+1, instr_valid=1 with pc=target at t+2 (1 cycle with bypass, see Configuration).
- Steady state: one instruction per cycle while deq_ready=1.
- Queue fills DEPTH cycles after decode stalls. Stall release gives back-to-back delivery with no bubble.
- count, pc and outputs are registered-state derived. Only instr_valid/instr depend combinationally on redirect and flush.
- After rst deasserts at edge e: first enq at e, first instr_valid=1 in the cycle after e.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count=0 and !redirect, the current fetch word and fetch_pc drive instr/imm/pc/pc_1 directly, and instr_valid=!flush.
  - If deq that cycle, the word is not enqueued; fetch_pc still advances.
  - Redirect-to-valid latency is 1 cycle.
- Undefined: no bypass. Empty queue gives instr_valid=0; latency 2 cycles.

## Structure
- Package fetch_pkg holds:
  - NOP constant
  - redirect_sel encodings (SEL_RDST_D, SEL_RDST_E, SEL_RET, SEL_ISR)
  - packed entry struct {word, pc}
- Sub-module fetch_queue: parametrised circular FIFO with push, pop, clear, count and head outputs. clear overrides push and pop.
- Top holds fetch_pc, instruction memory, target mux, return-address register and output masking.

## Test plan
- Reset, deq_ready=1, memory words 0x1111,0x2222,0x3333 at 0..2 -> pc=0,1,2 with instr 0x1111,0x2222,0x3333 on consecutive cycles starting the cycle after reset.
- deq_ready=0 for 6 cycles -> count saturates at 4 and fetch_pc stops advancing. Release -> pcs 0..4 delivered back-to-back with no gap.
- Queue full, redirect sel=01, Rdst_E=0x0040 -> count=0 next cycle; instr_valid=1 with pc=0x00000040 two cycles later (one with FETCH_BYPASS_EN).
- pop_en,pop_hi=1,WD=0x0001, then pop_en,pop_hi=0,WD=0x2000, then redirect sel=10 -> fetch resumes at pc=0x00012000.
- flush with count=2, deq_ready=1 -> instr=0, imm=head word, count stays 2 (full) or increments (not full); head delivered next cycle.
- rst asserted while redirect=1 and pop_en=1 -> next cycle fetch_pc=RESET_PC, count=0, ret_address=0.
